// File: rtl/eeprom_program_loader.sv
// Boot-time copier: reads LOAD_BYTES from the SPI EEPROM reader and writes them as
// little-endian 32-bit words to BASE_ADDRESS. `define LOADER_CHECKSUM_EN adds a checksum port.
//
// state      | meaning
// IDLE       | waiting for start after reset
// STROBE     | present byte address, pulse eeprom_strobe
// WAIT_BUSY  | dead cycle while the reader drops ready
// WAIT_READY | wait for ready (timeout counted), latch byte into its lane
// PACK       | advance byte counter, decide write or next byte
// WRITE      | single-cycle bus write of the word buffer
// WRITE_END  | release bus, clear word buffer
// FINISH     | image in RAM, done held
// ERROR      | reader timeout, error held
module eeprom_program_loader #(
  parameter int          LOAD_BYTES     = 2048,
  parameter logic [15:0] BASE_ADDRESS   = 16'hc000,
  parameter int          TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [10:0] eeprom_address,
  output logic        eeprom_strobe,
  input  logic        eeprom_ready,
  input  logic [7:0]  eeprom_data,
  output logic [15:0] mem_address,
  output logic [31:0] mem_write,
  output logic [3:0]  mem_write_mask,
  output logic        mem_bus_enable,
  output logic        mem_write_enable,
  output logic        busy,
  output logic        done,
  output logic        error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] LAST_BYTE = 12'(LOAD_BYTES - 1);
  localparam logic [11:0] LOAD_N    = 12'(LOAD_BYTES);

  typedef enum logic [3:0] {
    IDLE, STROBE, WAIT_BUSY, WAIT_READY, PACK, WRITE, WRITE_END, FINISH, ERROR
  } state_t;

  state_t        state, state_next;
  logic [11:0]   counter;
  logic [31:0]   word_buf;
  logic [TW-1:0] tcnt;
  logic [10:0]   addr_q;
  logic [11:0]   word_last;
  logic          restart;

  // counter has already moved past the last loaded byte when WRITE is reached
  assign word_last = counter - 12'd1;
  assign restart   = start && (state == IDLE || state == FINISH || state == ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      word_buf <= '0;
      tcnt     <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_next;
      if (restart) begin
        counter  <= '0;
        word_buf <= '0;
      end
      case (state)
        STROBE:    addr_q <= counter[10:0];
        WAIT_BUSY: tcnt   <= '0;
        WAIT_READY: begin
          if (eeprom_ready) word_buf[{counter[1:0], 3'b000} +: 8] <= eeprom_data;
          else              tcnt <= tcnt + TW'(1);
        end
        PACK:      counter  <= counter + 12'd1;
        WRITE_END: word_buf <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next       = state;
    eeprom_address   = addr_q;
    eeprom_strobe    = 1'b0;
    mem_address      = 16'h0000;
    mem_write        = 32'h0;
    mem_write_mask   = 4'b1111;
    mem_bus_enable   = 1'b0;
    mem_write_enable = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    error            = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = STROBE;
      end
      STROBE: begin
        eeprom_strobe  = 1'b1;
        eeprom_address = counter[10:0];
        state_next     = WAIT_BUSY;
      end
      WAIT_BUSY: state_next = WAIT_READY;
      WAIT_READY: begin
        if (eeprom_ready)      state_next = PACK;
        else if (tcnt == TMAX) state_next = ERROR;
      end
      PACK: begin
        if (counter[1:0] == 2'd3 || counter == LAST_BYTE) state_next = WRITE;
        else                                              state_next = STROBE;
      end
      WRITE: begin
        mem_address      = BASE_ADDRESS + {4'b0000, word_last[11:2], 2'b00};
        mem_write        = word_buf;
        // lanes 0..word_last[1:0] were loaded; a full word shifts the mask to 0000
        mem_write_mask   = 4'b1110 << word_last[1:0];
        mem_bus_enable   = 1'b1;
        mem_write_enable = 1'b1;
        state_next       = WRITE_END;
      end
      WRITE_END: state_next = (counter == LOAD_N) ? FINISH : STROBE;
      FINISH: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_next = STROBE;
      end
      ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_next = STROBE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] lane_byte;

  assign lane_byte = word_buf[{counter[1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset)              sum_q <= 8'h00;
    else if (restart)       sum_q <= 8'h00;
    else if (state == PACK) sum_q <= sum_q + lane_byte;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_eeprom_program_loader.sv
// Randomized bench for eeprom_program_loader: EEPROM responder with per-byte latency,
// transaction-level model of expected strobes/bus writes, per-cycle output monitor.
module tb_eeprom_program_loader;
  localparam int          N    = 5;
  localparam int          TMO  = 16;
  localparam logic [15:0] BASE = 16'hc000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        eeprom_ready = 1'b1;
  logic [7:0]  eeprom_data = 8'h00;
  logic [10:0] eeprom_address;
  logic        eeprom_strobe;
  logic [15:0] mem_address;
  logic [31:0] mem_write;
  logic [3:0]  mem_write_mask;
  logic        mem_bus_enable, mem_write_enable, busy, done, error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  always #5 clk = ~clk;

  eeprom_program_loader #(.LOAD_BYTES(N), .BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .eeprom_address(eeprom_address), .eeprom_strobe(eeprom_strobe),
    .eeprom_ready(eeprom_ready), .eeprom_data(eeprom_data),
    .mem_address(mem_address), .mem_write(mem_write), .mem_write_mask(mem_write_mask),
    .mem_bus_enable(mem_bus_enable), .mem_write_enable(mem_write_enable),
    .busy(busy), .done(done), .error(error)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic [7:0] img [N];
  int         lat [N];
  wr_t        wq [$];
  int         strobe_cnt = 0;

  // expected bus writes for the first nb bytes of img
  function automatic void build_writes(input int nb);
    wq.delete();
    for (int w = 0; 4 * w < nb; w++) begin
      wr_t e;
      int  cnt;
      cnt = (nb - 4 * w >= 4) ? 4 : nb - 4 * w;
      e.a = BASE + 16'(4 * w);
      e.d = 32'h0;
      e.m = 4'hF;
      for (int b = 0; b < cnt; b++) begin
        e.d[8 * b +: 8] = img[4 * w + b];
        e.m[b] = 1'b0;
      end
      wq.push_back(e);
    end
  endfunction

  function automatic int first_timeout();
    for (int i = 0; i < N; i++)
      if (lat[i] >= TMO) return i;
    return -1;
  endfunction

  function automatic logic [7:0] img_sum();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < N; i++) s = s + img[i];
    return s;
  endfunction

  // ---------------- EEPROM reader responder ----------------
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (eeprom_strobe) begin
        a = int'(eeprom_address);
        if (a >= N) a = 0;
        eeprom_ready = 1'b0;
        eeprom_data  = 8'($urandom);
        repeat (2 + lat[a]) @(negedge clk);
        eeprom_data  = img[a];
        eeprom_ready = 1'b1;
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  initial begin
    logic prev_strobe;
    wr_t  e;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      check("we_follows_be", mem_write_enable, mem_bus_enable);
      if (!mem_bus_enable) check("idle_mask", mem_write_mask, 4'hF);
      check("busy_excl_done_err", busy & (done | error), 1'b0);
      check("strobe_one_cycle", eeprom_strobe & prev_strobe, 1'b0);
      prev_strobe = eeprom_strobe;
      if (eeprom_strobe) begin
        check("strobe_addr", eeprom_address, strobe_cnt);
        strobe_cnt++;
      end
      if (mem_bus_enable) begin
        if (wq.size() == 0) begin
          check("unexpected_write_addr", mem_address, 16'hxxxx);
        end else begin
          e = wq.pop_front();
          check("wr_addr", mem_address, e.a);
          check("wr_data", mem_write, e.d);
          check("wr_mask", mem_write_mask, e.m);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wait_reader_idle();
    int g = 0;
    while (!eeprom_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("reader_idle", eeprom_ready, 1'b1);
  endtask

  task automatic run_copy(input bit inject_busy_start, output int cyc);
    int k, nb;
    wait_reader_idle();
    @(posedge clk); #1;
    k  = first_timeout();
    nb = (k >= 0) ? (k / 4) * 4 : N;
    build_writes(nb);
    strobe_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done_clr", done, 1'b0);
    check("start_err_clr", error, 1'b0);
    cyc = 0;
    if (inject_busy_start) begin
      repeat ($urandom_range(2, 10)) begin @(posedge clk); #1; cyc++; end
      start = 1'b1;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end
    while (!(done || error) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("finish_in_time", cyc < 3000, 1'b1);
    check("done_end", done, k < 0);
    check("error_end", error, k >= 0);
    check("busy_end", busy, 1'b0);
    @(negedge clk); #1;
    check("strobe_count", strobe_cnt, (k >= 0) ? k + 1 : N);
    check("writes_left", wq.size(), 0);
`ifdef LOADER_CHECKSUM_EN
    if (k < 0) check("checksum", checksum, img_sum());
`endif
  endtask

  task automatic reset_during_write();
    int g = 0;
    wait_reader_idle();
    @(posedge clk); #1;
    build_writes(N);
    strobe_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!mem_bus_enable && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("reached_write", mem_bus_enable, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_be", mem_bus_enable, 1'b0);
    check("rst_we", mem_write_enable, 1'b0);
    check("rst_mask", mem_write_mask, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strobe", eeprom_strobe, 1'b0);
    @(negedge clk); #1;
    wq.delete();
    strobe_cnt = 0;
  endtask

  task automatic randomize_image(input int max_lat);
    for (int i = 0; i < N; i++) begin
      img[i] = 8'($urandom);
      lat[i] = $urandom_range(0, max_lat);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    for (int i = 0; i < N; i++) begin img[i] = 8'h00; lat[i] = 0; end

    repeat (2) @(posedge clk);
    #1;
    check("rst_eeprom_address", eeprom_address, 11'h000);
    check("rst_eeprom_strobe", eeprom_strobe, 1'b0);
    check("rst_mem_address", mem_address, 16'h0000);
    check("rst_mem_write", mem_write, 32'h0);
    check("rst_mem_mask", mem_write_mask, 4'hF);
    check("rst_mem_enables", {mem_bus_enable, mem_write_enable}, 2'b00);
    check("rst_flags", {busy, done, error}, 3'b000);
    reset = 1'b0;

    // pin the model with a hand-computed image
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
    build_writes(N);
    check("model_nwrites", wq.size(), 2);
    check("model_w0_addr", wq[0].a, 16'hc000);
    check("model_w0_data", wq[0].d, 32'hDDCCBBAA);
    check("model_w0_mask", wq[0].m, 4'b0000);
    check("model_w1_addr", wq[1].a, 16'hc004);
    check("model_w1_data", wq[1].d, 32'h000000EE);
    check("model_w1_mask", wq[1].m, 4'b1110);
    wq.delete();

    // directed: AA..EE with immediate ready
    run_copy(1'b0, cyc);

    // randomized images and reader latencies; includes start-while-busy and restart-from-done
    for (int r = 0; r < 8; r++) begin
      randomize_image(8);
      if (r == 3) lat[$urandom_range(0, N - 1)] = TMO - 1;
      run_copy(r[0], cyc);
    end

    // ready never returns on byte 0: error after 16 wait cycles, no bus write
    randomize_image(3);
    lat[0] = TMO;
    run_copy(1'b0, cyc);
    check("timeout_latency", cyc, 18);

    // restart after error begins again at address 0
    randomize_image(4);
    run_copy(1'b0, cyc);

    // timeout on byte 4: first full word already written, nothing after
    randomize_image(4);
    lat[4] = TMO + $urandom_range(0, 3);
    run_copy(1'b0, cyc);

    randomize_image(5);
    lat[$urandom_range(1, 3)] = TMO;
    run_copy(1'b1, cyc);

    // reset in WRITE, then a clean copy from byte 0
    randomize_image(3);
    reset_during_write();
    randomize_image(6);
    run_copy(1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
